// File: rtl/gmii_rx_slot_writer.sv
// GMII receive front end: strips preamble/SFD, writes frame bytes into the RX slot RAM
// (port B), checks FCS/length/rx_er and publishes length and timestamp of good frames.
module gmii_rx_slot_writer #(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        gmii_rx_clk,
  input  logic        rstn,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [31:0] global_counter,
  input  logic        rx_empty,
  output logic [15:0] slot_data,
  output logic [1:0]  slot_byte_en,
  output logic [11:0] slot_address,
  output logic        slot_wr_en,
  output logic [31:0] rx_timestamp,
  output logic [11:0] rx_frame_len,
  output logic        rx_complete,
  output logic [15:0] rx_drop_cnt,
  output logic [15:0] rx_crc_err_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  localparam logic [11:0] MAX_CNT = 12'(MAX_LEN);
  localparam logic [11:0] MIN_CNT = 12'(MIN_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [1:0]  state;
  logic [11:0] byte_cnt;
  logic [31:0] crc;
  logic [31:0] ts_pend;

  // Reflected CRC-32, one byte per call, LSB first as bytes arrive on GMII.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge gmii_rx_clk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      byte_cnt       <= 12'd0;
      crc            <= 32'd0;
      ts_pend        <= 32'd0;
      slot_data      <= 16'd0;
      slot_byte_en   <= 2'd0;
      slot_address   <= 12'd0;
      slot_wr_en     <= 1'b0;
      rx_timestamp   <= 32'd0;
      rx_frame_len   <= 12'd0;
      rx_complete    <= 1'b0;
      rx_drop_cnt    <= 16'd0;
      rx_crc_err_cnt <= 16'd0;
    end else begin
      slot_wr_en  <= 1'b0;
      rx_complete <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gmii_rx_dv) begin
            state <= (gmii_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
          end
        end
        S_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            // The slot is claimed only here; a later rx_empty change does not matter.
            if (rx_empty) begin
              state    <= S_DATA;
              ts_pend  <= global_counter;
              byte_cnt <= 12'd0;
              crc      <= 32'hFFFFFFFF;
            end else begin
              state       <= S_DROP;
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end
          end else if (gmii_rxd != 8'h55) begin
            state <= S_DROP;
          end
        end
        S_DATA: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_er || (byte_cnt == MAX_CNT)) begin
              state       <= S_DROP;
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end else begin
              slot_wr_en   <= 1'b1;
              slot_address <= {1'b0, byte_cnt[11:1]};
              slot_byte_en <= byte_cnt[0] ? 2'b01 : 2'b10;
              slot_data    <= byte_cnt[0] ? {8'h00, gmii_rxd} : {gmii_rxd, 8'h00};
              byte_cnt     <= byte_cnt + 12'd1;
              crc          <= crc_byte(crc, gmii_rxd);
            end
          end else begin
            state <= S_IDLE;
            if (byte_cnt < MIN_CNT) begin
              rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end else if (crc != CRC_RESIDUE) begin
              rx_crc_err_cnt <= rx_crc_err_cnt + 16'd1;
            end else begin
              rx_frame_len <= byte_cnt;
              rx_timestamp <= ts_pend;
              rx_complete  <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!gmii_rx_dv) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_slot_writer.sv
// Directed plus randomized frames against a frame-level model of the RX slot writer.
module tb_gmii_rx_slot_writer;

  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [31:0] global_counter;
  logic        rx_empty;
  logic [15:0] slot_data;
  logic [1:0]  slot_byte_en;
  logic [11:0] slot_address;
  logic        slot_wr_en;
  logic [31:0] rx_timestamp;
  logic [11:0] rx_frame_len;
  logic        rx_complete;
  logic [15:0] rx_drop_cnt;
  logic [15:0] rx_crc_err_cnt;

  gmii_rx_slot_writer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .gmii_rx_clk(clk),
    .rstn(rstn),
    .gmii_rxd(gmii_rxd),
    .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er),
    .global_counter(global_counter),
    .rx_empty(rx_empty),
    .slot_data(slot_data),
    .slot_byte_en(slot_byte_en),
    .slot_address(slot_address),
    .slot_wr_en(slot_wr_en),
    .rx_timestamp(rx_timestamp),
    .rx_frame_len(rx_frame_len),
    .rx_complete(rx_complete),
    .rx_drop_cnt(rx_drop_cnt),
    .rx_crc_err_cnt(rx_crc_err_cnt)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed writes {cycle, address, byte_en, data} and commit pulse cycles
  logic [61:0] wr_q[$];
  int          cmp_q[$];
  always @(negedge clk) begin
    if (slot_wr_en === 1'b1) wr_q.push_back({cyc, slot_address, slot_byte_en, slot_data});
    if (rx_complete === 1'b1) cmp_q.push_back(cyc);
  end

  // scoreboard / model state
  logic [61:0] exp_q[$];
  int          exp_cmp_q[$];
  logic [15:0] exp_drop;
  logic [15:0] exp_crc;
  logic [11:0] exp_len;
  logic [31:0] exp_ts;
  logic [7:0]  fbuf[0:1699];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // standard Ethernet FCS of fbuf[0..len-1] (final value, already inverted)
  function automatic logic [31:0] fcs_of(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ fbuf[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n);
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) fbuf[i] = 8'($urandom);
    f = fcs_of(n - 4);
    fbuf[n-4] = f[7:0];
    fbuf[n-3] = f[15:8];
    fbuf[n-2] = f[23:16];
    fbuf[n-1] = f[31:24];
  endtask

  // driver: one GMII cycle; unrelated inputs wander randomly
  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(negedge clk);
    gmii_rx_dv     = dv;
    gmii_rxd       = d;
    gmii_rx_er     = er;
    global_counter = $urandom;
    rx_empty       = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Sends preamble, SFD, fbuf[0..n-1], then one dv=0 cycle; predicts all effects.
  task automatic send_frame(input int n, input logic empty, input int er_at,
                            input int rst_at, input logic [31:0] ts);
    int limit;
    logic fcs_ok;
    logic good;
    fcs_ok = (fcs_of(n - 4) == {fbuf[n-1], fbuf[n-2], fbuf[n-3], fbuf[n-4]});
    limit = empty ? n : 0;
    if (er_at >= 0 && er_at < limit) limit = er_at;
    if (MAX_LEN < limit) limit = MAX_LEN;
    if (rst_at >= 0 && rst_at < limit) limit = rst_at;
    good = 1'b0;
    if (rst_at < 0) begin
      if (!empty || (er_at >= 0 && er_at < n) || n > MAX_LEN || n < MIN_LEN) exp_drop = exp_drop + 16'd1;
      else if (!fcs_ok) exp_crc = exp_crc + 16'd1;
      else good = 1'b1;
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    global_counter = ts;
    rx_empty = empty;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, fbuf[i], i == er_at);
      rstn = (i == rst_at) ? 1'b0 : 1'b1;
      if (i == rst_at) begin
        exp_drop = 16'd0;
        exp_crc  = 16'd0;
        exp_len  = 12'd0;
        exp_ts   = 32'd0;
      end
      if (i < limit)
        exp_q.push_back({cyc + 1, 12'(i >> 1), (i % 2 == 1) ? 2'b01 : 2'b10,
                         (i % 2 == 1) ? {8'h00, fbuf[i]} : {fbuf[i], 8'h00}});
    end
    drive(1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
    if (good) begin
      exp_cmp_q.push_back(cyc + 1);
      exp_len = 12'(n);
      exp_ts  = ts;
    end
  endtask

  task automatic check_all(input string tag);
    int mis;
    idle(4);
    check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    mis = 0;
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) mis++;
    check({tag, "_wr_mismatch"}, 64'(mis), 64'd0);
    check({tag, "_complete_count"}, 64'(cmp_q.size()), 64'(exp_cmp_q.size()));
    mis = 0;
    for (int i = 0; i < cmp_q.size() && i < exp_cmp_q.size(); i++)
      if (cmp_q[i] != exp_cmp_q[i]) mis++;
    check({tag, "_complete_cycle"}, 64'(mis), 64'd0);
    check({tag, "_drop_cnt"}, 64'(rx_drop_cnt), 64'(exp_drop));
    check({tag, "_crc_err_cnt"}, 64'(rx_crc_err_cnt), 64'(exp_crc));
    check({tag, "_frame_len"}, 64'(rx_frame_len), 64'(exp_len));
    check({tag, "_timestamp"}, 64'(rx_timestamp), 64'(exp_ts));
    wr_q.delete();
    cmp_q.delete();
    exp_q.delete();
    exp_cmp_q.delete();
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    gmii_rx_er = 1'b0;
    global_counter = 32'd0;
    rx_empty = 1'b0;
    exp_drop = 16'd0;
    exp_crc = 16'd0;
    exp_len = 12'd0;
    exp_ts = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_wr_en", 64'(slot_wr_en), 64'd0);
    check("reset_slot_bus", 64'({slot_data, slot_byte_en, slot_address}), 64'd0);
    check("reset_complete", 64'(rx_complete), 64'd0);
    check("reset_counters", 64'({rx_drop_cnt, rx_crc_err_cnt}), 64'd0);
    check("reset_len_ts", 64'({rx_frame_len, rx_timestamp}), 64'd0);
    rstn = 1'b1;
    wr_q.delete();
    cmp_q.delete();
    idle(2);

    build_frame(64);
    send_frame(64, 1'b1, -1, -1, 32'h1000);
    check_all("good64");

    build_frame(65);
    send_frame(65, 1'b1, -1, -1, 32'h2345);
    check_all("good65");

    build_frame(65);
    fbuf[10] = fbuf[10] ^ 8'h04;
    send_frame(65, 1'b1, -1, -1, 32'h3000);
    check_all("crc_flip");

    build_frame(70);
    send_frame(70, 1'b0, -1, -1, 32'h4000);
    build_frame(80);
    send_frame(80, 1'b1, -1, -1, 32'h4444);
    check_all("busy_then_b2b");

    build_frame(1600);
    send_frame(1600, 1'b1, -1, -1, 32'h5000);
    check_all("too_long");

    build_frame(60);
    send_frame(60, 1'b1, -1, -1, 32'h6000);
    check_all("too_short");

    build_frame(100);
    send_frame(100, 1'b1, 20, -1, 32'h7000);
    check_all("rx_er");

    build_frame(100);
    fbuf[31] = 8'h00;
    send_frame(100, 1'b1, -1, 30, 32'h8000);
    check_all("mid_reset");
    build_frame(90);
    send_frame(90, 1'b1, -1, -1, 32'h9000);
    check_all("after_reset");

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(50, 200);
      build_frame(n);
      if ($urandom_range(0, 3) == 0) fbuf[$urandom_range(0, n - 1)] ^= 8'h01;
      send_frame(n, ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1,
                 -1, $urandom);
      idle($urandom_range(0, 2));
    end
    check_all("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmii_rx_slot_writer.md
# gmii_rx_slot_writer

Receive-side front end of an ethpipe port. It sits in the `gmii_rx_clk` domain between the PHY GMII receive pins and port B of the RX-slot true dual-port RAM, whose port A is served by the PCIe/Wishbone register block. It strips preamble/SFD and writes frame bytes (including FCS) into the slot. It checks CRC-32, length and `rx_er`, then publishes timestamp and length and pulses `rx_complete` for good frames only.

## Interface
Parameters:
- `MAX_LEN`, 1522: maximum accepted frame length in bytes, DA through FCS; must be ≤ 4095.
- `MIN_LEN`, 64: minimum accepted frame length in bytes.

Ports:
- `gmii_rx_clk` in 1: the only clock.
- `rstn` in 1: reset, synchronous, active-low.
- `gmii_rxd` in 8: GMII receive data.
- `gmii_rx_dv` in 1: GMII data valid.
- `gmii_rx_er` in 1: GMII receive error.
- `global_counter` in 32: free-running timestamp source, already valid in this domain.
- `rx_empty` in 1: high means the host has released the slot.
- `slot_data` out 16: RAM port B write data.
- `slot_byte_en` out 2: bit1 enables [15:8], bit0 enables [7:0].
- `slot_address` out 12: RAM port B word address.
- `slot_wr_en` out 1: RAM port B write strobe.
- `rx_timestamp` out 32: SFD timestamp of the last committed frame.
- `rx_frame_len` out 12: byte length of the last committed frame, including FCS.
- `rx_complete` out 1: one-cycle pulse when a good frame is committed.
- `rx_drop_cnt` out 16: frames dropped because the slot was busy, or on length or `rx_er` errors; wraps.
- `rx_crc_err_cnt` out 16: frames dropped on bad FCS; wraps.

## Operation
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE
  - `dv`=1 and `rxd`=0x55 → PREAMBLE.
  - `dv`=1 and any other value → DROP, not counted. This covers reset release mid-frame.
- PREAMBLE
  - `dv`=0 → IDLE.
  - 0x55 → stay.
  - 0xD5 with `rx_empty`=1 → DATA: latch `global_counter` into the pending timestamp, clear `byte_cnt`, preset CRC to 0xFFFFFFFF.
  - 0xD5 with `rx_empty`=0 → DROP, `rx_drop_cnt`+1.
  - Any other byte → DROP, not counted.
- DATA, each cycle with `dv`=1:
  - Write byte n (n = `byte_cnt`) to word address n>>1.
  - n even: byte_en 2'b10, data {byte,8'h00}.
  - n odd: byte_en 2'b01, data {8'h00,byte}.
  - `byte_cnt`+1, CRC-32 (reflected polynomial 0xEDB88320) updated with the byte.
- DATA aborts to DROP with `rx_drop_cnt`+1 when:
  - `rx_er`=1 while `dv`=1; or
  - `byte_cnt` would exceed `MAX_LEN`; writes stop immediately.
- DATA end, on `dv`=0 (commit evaluation):
  - `byte_cnt` < `MIN_LEN` → `rx_drop_cnt`+1.
  - Otherwise CRC register ≠ residue 0xDEBB20E3 → `rx_crc_err_cnt`+1.
  - Otherwise commit: `rx_frame_len` ← `byte_cnt`, `rx_timestamp` ← pending timestamp, `rx_complete` pulse.
  - Next state is IDLE in all cases.
- DROP: no writes; exits to IDLE on the first cycle with `dv`=0.
- A dropped frame may leave partial data in the slot. `rx_frame_len` and `rx_timestamp` change only on commit.
- `rx_empty` is sampled only at SFD. Deassertion mid-frame does not abort the frame.
- Both counters wrap from 0xFFFF to 0. A single frame increments at most one counter.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state is IDLE.
- Write latency: the byte sampled in cycle t appears on `slot_*` with `slot_wr_en`=1 in cycle t+1; `slot_wr_en` is 0 in all other cycles.
- Commit: `dv` falls in cycle t (evaluation); in cycle t+1 `rx_frame_len`/`rx_timestamp` are updated and `rx_complete`=1 for exactly that cycle. Counter increments are visible in t+1.
- The timestamp is the `global_counter` value sampled in the SFD cycle.
- Back-to-back frames with a 1-cycle `dv` gap are accepted; the commit of frame k overlaps the preamble of frame k+1.
- `rstn`=0 mid-frame: the next edge returns all state and outputs to reset values. No commit occurs and `rx_complete` is not emitted.

## Test plan
- 64-byte valid frame (7×0x55, 0xD5, payload, correct FCS), `rx_empty`=1, `global_counter`=0x1000 at SFD → 64 writes at addresses 0..31 with alternating byte_en 10/01; `rx_frame_len`=64, `rx_timestamp`=0x1000, one `rx_complete` pulse one cycle after `dv` falls.
- 65-byte frame with good FCS → last write at address 32 with byte_en 2'b10; `rx_frame_len`=65.
- Same frame with one payload bit flipped → no `rx_complete`, `rx_crc_err_cnt`=1, `rx_frame_len`/`rx_timestamp` unchanged.
- `rx_empty`=0 at SFD → zero writes, `rx_drop_cnt`=1. A second frame with `rx_empty`=1 after a 1-cycle gap commits normally.
- 1600-byte frame → writes stop after byte 1522, `rx_drop_cnt`+1, no pulse. A 60-byte frame → `rx_drop_cnt`+1. `rx_er` asserted at byte 20 → `rx_drop_cnt`+1, no further writes.
- `rstn` low for 1 cycle at byte 30, then released with `dv` still high → no writes until the next preamble; the next good frame commits with correct length.
